// File: rtl/gsm_cmd_scheduler_if.sv
// Command-port bundle between the gsm requesters and the scheduler.
// The master side is the requester/gsm environment; the slave side is the scheduler.
interface gsm_cmd_scheduler_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req;
  logic [4*NREQ-1:0] req_flag;
  logic [NREQ-1:0]   ack;
  logic [NREQ-1:0]   err;
  logic [3:0]        gsm_flag;
  logic              gsm_trig;
  logic              gsm_done;
  logic              busy;

  modport master (
    output req, req_flag, gsm_done,
    input  ack, err, gsm_flag, gsm_trig, busy
  );

  modport slave (
    input  req, req_flag, gsm_done,
    output ack, err, gsm_flag, gsm_trig, busy
  );
endinterface

// File: rtl/gsm_cmd_scheduler.sv
// Shares the single flag/trig/done command port of the game state manager among
// NREQ requesters: fixed-priority arbitration (state transitions first, then
// lowest index), trig held until done or timeout, then a trig-low gap so the
// gsm's two-flop synchroniser sees a clean low between commands.
module gsm_cmd_scheduler #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 8,
  parameter int LOW_GAP = 2
) (
  input logic                clk_1mhz,
  input logic                rst_n,
  gsm_cmd_scheduler_if.slave bus
);

  // One counter serves both the WAIT timeout and the GAP length.
  localparam int CNT_MAX = (TIMEOUT > LOW_GAP) ? TIMEOUT : LOW_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam int IDX_W   = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  grant_q, grant_d;
  logic [3:0]        flag_q, flag_d;
  logic              trig_q, trig_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic [NREQ-1:0]   err_q, err_d;

  logic              win_valid;
  logic [IDX_W-1:0]  win_idx;
  logic [3:0]        win_code;

  function automatic logic is_legal(input logic [3:0] code);
    case (code)
      4'b0001, 4'b0010, 4'b0100, 4'b0101, 4'b1000,
      4'b1010, 4'b1100, 4'b1101, 4'b1110, 4'b1111: is_legal = 1'b1;
      default:                                      is_legal = 1'b0;
    endcase
  endfunction

  // Winner selection: a requester being acked this cycle is masked so its
  // still-high req (dropped one cycle later) is not served twice.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can leave it unassigned and infer a latch.
    win_valid = 1'b0;
    win_idx   = '0;
    win_code  = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (bus.req[i] && !ack_q[i] && !bus.req_flag[4*i+3]) begin
        win_valid = 1'b1;
        win_idx   = IDX_W'(i);
      end
    end
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (bus.req[i] && !ack_q[i] && bus.req_flag[4*i+3]) begin
        win_valid = 1'b1;
        win_idx   = IDX_W'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx == IDX_W'(i)) win_code = bus.req_flag[4*i +: 4];
    end
  end

  // Next-state and output logic of the IDLE -> WAIT -> GAP command sequence.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    flag_d  = flag_q;
    trig_d  = trig_q;
    ack_d   = '0;
    err_d   = '0;
    case (state_q)
      IDLE: begin
        if (win_valid) begin
          if (!is_legal(win_code)) begin
            ack_d[win_idx] = 1'b1;
            err_d[win_idx] = 1'b1;
          end else begin
            flag_d  = win_code;
            trig_d  = 1'b1;
            cnt_d   = '0;
            grant_d = win_idx;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (bus.gsm_done) begin
          trig_d         = 1'b0;
          ack_d[grant_q] = 1'b1;
          cnt_d          = '0;
          state_d        = GAP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          trig_d         = 1'b0;
          ack_d[grant_q] = 1'b1;
          err_d[grant_q] = 1'b1;
          cnt_d          = '0;
          state_d        = GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == CNT_W'(LOW_GAP - 1)) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk_1mhz) begin
    // NOTE: non-blocking assignments here so every register samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      grant_q <= '0;
      flag_q  <= 4'b0000;
      trig_q  <= 1'b0;
      ack_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      flag_q  <= flag_d;
      trig_q  <= trig_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  assign bus.gsm_flag = flag_q;
  assign bus.gsm_trig = trig_q;
  assign bus.ack      = ack_q;
  assign bus.err      = err_q;
  assign bus.busy     = (state_q != IDLE);

endmodule

// File: tb/tb_gsm_cmd_scheduler.sv
// Directed bench for gsm_cmd_scheduler with a small gsm responder model
// (done rises on the third cycle of trig) and requesters that drop req the
// cycle after their ack.
module tb_gsm_cmd_scheduler;

  logic clk_1mhz = 1'b0;
  logic rst_n;

  always #5 clk_1mhz = ~clk_1mhz;

  gsm_cmd_scheduler_if #(.NREQ(4)) bus ();

  gsm_cmd_scheduler #(
    .NREQ   (4),
    .TIMEOUT(8),
    .LOW_GAP(2)
  ) dut (
    .clk_1mhz(clk_1mhz),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // trig waveform tracking
  bit trig_prev = 1'b0;
  bit fell_once = 1'b0;
  int hi_run    = 0;
  int low_run   = 0;
  int trig_len  = 0;
  int rise_cyc  = 0;
  int min_low   = 1000;
  bit trig_seen = 1'b0;
  bit busy_seen = 1'b0;

  // gsm model
  bit         gsm_en    = 1'b1;
  int         thi       = 0;
  int         score     = 0;
  logic [2:0] gsm_state = 3'b001;
  logic [3:0] gsm_log[$];

  // requester bookkeeping
  logic [3:0] ack_prev = '0;
  int ack_idx_q[$];
  int ack_err_q[$];
  int ack_cyc_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: sample at the falling edge, update trackers, gsm model and requesters.
  task automatic step();
    @(negedge clk_1mhz);
    cyc++;
    check("ack_onehot", 32'($countones(bus.ack) <= 1), 32'd1);
    check("err_implies_ack", 32'(bus.err & ~bus.ack), 32'd0);
    if (bus.gsm_trig) trig_seen = 1'b1;
    if (bus.busy) busy_seen = 1'b1;
    if (bus.gsm_trig) begin
      if (!trig_prev) begin
        rise_cyc = cyc;
        if (fell_once && low_run < min_low) min_low = low_run;
      end
      hi_run++;
      low_run = 0;
    end else begin
      if (trig_prev) begin
        trig_len  = hi_run;
        fell_once = 1'b1;
      end
      hi_run = 0;
      low_run++;
    end
    trig_prev = bus.gsm_trig;
    if (bus.gsm_trig) thi++;
    else thi = 0;
    if (gsm_en && bus.gsm_trig && thi == 3) begin
      gsm_log.push_back(bus.gsm_flag);
      if (bus.gsm_flag == 4'b0001) score++;
      if (bus.gsm_flag[3]) gsm_state = bus.gsm_flag[2:0];
    end
    bus.gsm_done = gsm_en && bus.gsm_trig && (thi >= 3);
    for (int i = 0; i < 4; i++) begin
      if (ack_prev[i]) bus.req[i] = 1'b0;
      if (bus.ack[i]) begin
        ack_idx_q.push_back(i);
        ack_err_q.push_back(int'(bus.err[i]));
        ack_cyc_q.push_back(cyc);
      end
    end
    ack_prev = bus.ack;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic begin_test();
    fell_once = 1'b0;
    min_low   = 1000;
    trig_seen = 1'b0;
    busy_seen = 1'b0;
  endtask

  task automatic post_req(input int idx, input logic [3:0] code);
    bus.req_flag[4*idx +: 4] = code;
    bus.req[idx] = 1'b1;
  endtask

  task automatic wait_acks(input int n, input int bound);
    int target;
    target = ack_idx_q.size() + n;
    for (int k = 0; k < bound && ack_idx_q.size() < target; k++) step();
    check("ack_count", 32'(ack_idx_q.size()), 32'(target));
  endtask

  initial begin
    int base;
    rst_n        = 1'b0;
    bus.req      = '0;
    bus.req_flag = '0;
    bus.gsm_done = 1'b0;

    // Reset state
    idle(2);
    check("rst_trig", 32'(bus.gsm_trig), 32'd0);
    check("rst_flag", 32'(bus.gsm_flag), 32'd0);
    check("rst_ack", 32'(bus.ack), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    rst_n = 1'b1;
    idle(2);

    // Single legal command: trig high 3 cycles, ack 3 cycles after rise
    begin_test();
    post_req(0, 4'b0001);
    wait_acks(1, 30);
    check("a_idx", 32'(ack_idx_q[$]), 32'd0);
    check("a_err", 32'(ack_err_q[$]), 32'd0);
    check("a_trig_len", 32'(trig_len), 32'd3);
    check("a_latency", 32'(ack_cyc_q[$] - rise_cyc), 32'd3);
    check("a_score", 32'(score), 32'd1);
    idle(6);
    check("a_busy_idle", 32'(bus.busy), 32'd0);
    check("a_flag_kept", 32'(bus.gsm_flag), 32'b0001);

    // Two simultaneous requests: state transition (req2) beats update (req0)
    begin_test();
    base = ack_idx_q.size();
    post_req(0, 4'b0001);
    post_req(2, 4'b1010);
    wait_acks(2, 60);
    check("b_first", 32'(ack_idx_q[base]), 32'd2);
    check("b_second", 32'(ack_idx_q[base+1]), 32'd0);
    check("b_log_first", 32'(gsm_log[gsm_log.size()-2]), 32'b1010);
    check("b_log_second", 32'(gsm_log[gsm_log.size()-1]), 32'b0001);
    check("b_state", 32'(gsm_state), 32'b010);
    check("b_low_gap", 32'(min_low), 32'd3);
    check("b_score", 32'(score), 32'd2);
    idle(6);

    // Illegal code: ack+err next cycle, no trig, never busy, no repeat ack
    begin_test();
    base = ack_idx_q.size();
    post_req(1, 4'b0011);
    step();
    check("c_ack", 32'(bus.ack), 32'b0010);
    check("c_err", 32'(bus.err), 32'b0010);
    idle(5);
    check("c_ack_total", 32'(ack_idx_q.size()), 32'(base + 1));
    check("c_trig_seen", 32'(trig_seen), 32'd0);
    check("c_busy_seen", 32'(busy_seen), 32'd0);

    // gsm never answers: trig high exactly TIMEOUT cycles, then ack+err
    begin_test();
    gsm_en = 1'b0;
    post_req(3, 4'b1100);
    wait_acks(1, 40);
    check("d_idx", 32'(ack_idx_q[$]), 32'd3);
    check("d_err", 32'(ack_err_q[$]), 32'd1);
    check("d_trig_len", 32'(trig_len), 32'd8);
    check("d_latency", 32'(ack_cyc_q[$] - rise_cyc), 32'd8);
    gsm_en = 1'b1;
    idle(6);

    // Four requests at once: order 2,3 (transitions) then 0,1 (updates)
    begin_test();
    base = ack_idx_q.size();
    post_req(0, 4'b0001);
    post_req(1, 4'b0100);
    post_req(2, 4'b1000);
    post_req(3, 4'b1101);
    wait_acks(4, 100);
    check("e_ord0", 32'(ack_idx_q[base]), 32'd2);
    check("e_ord1", 32'(ack_idx_q[base+1]), 32'd3);
    check("e_ord2", 32'(ack_idx_q[base+2]), 32'd0);
    check("e_ord3", 32'(ack_idx_q[base+3]), 32'd1);
    check("e_errs", 32'(ack_err_q[base] + ack_err_q[base+1] + ack_err_q[base+2] + ack_err_q[base+3]), 32'd0);
    check("e_low_gap", 32'(min_low), 32'd3);
    check("e_state", 32'(gsm_state), 32'b101);
    check("e_score", 32'(score), 32'd3);
    idle(6);

    // Reset while waiting on gsm: trig drops, no ack; held req is re-served
    begin_test();
    base = ack_idx_q.size();
    post_req(0, 4'b0001);
    for (int k = 0; k < 10 && !bus.gsm_trig; k++) step();
    check("f_trig_rose", 32'(bus.gsm_trig), 32'd1);
    rst_n = 1'b0;
    step();
    check("f_rst_trig", 32'(bus.gsm_trig), 32'd0);
    check("f_rst_busy", 32'(bus.busy), 32'd0);
    check("f_rst_ack", 32'(bus.ack), 32'd0);
    rst_n = 1'b1;
    wait_acks(1, 30);
    check("f_no_abort_ack", 32'(ack_idx_q.size()), 32'(base + 1));
    check("f_idx", 32'(ack_idx_q[$]), 32'd0);
    check("f_err", 32'(ack_err_q[$]), 32'd0);
    check("f_trig_len", 32'(trig_len), 32'd3);
    check("f_score", 32'(score), 32'd4);
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
